// File: rtl/vga_hw_sink_pkg.sv
// Shared constants and types for the VGA hardware sink: default timing, address window,
// framebuffer geometry and write-handshake state encoding.
package vga_hw_sink_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0010_0000;
    localparam int DEF_FB_W     = 160;
    localparam int DEF_FB_H     = 120;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Both scan counters share one width; line and frame totals must stay below 1024.
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_t;

    function automatic logic in_window(input logic [31:0] off, input int depth);
        return off < 32'(depth);
    endfunction

endpackage

// File: rtl/vga_hw_sink_timing.sv
// Horizontal/vertical scan counters with combinational sync and active-area flags
// decoded from the current count.
module vga_hw_sink_timing
    import vga_hw_sink_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_active
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;

    assign w_h_wrap = (r_h_cnt == CNT_W'(H_TOTAL - 1));
    assign w_v_wrap = (r_v_cnt == CNT_W'(V_TOTAL - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + CNT_W'(1);
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + CNT_W'(1);
            end
        end
    end

    assign o_h_cnt  = r_h_cnt;
    assign o_v_cnt  = r_v_cnt;
    assign o_hsync  = !((r_h_cnt >= CNT_W'(H_ACTIVE + H_FP)) &&
                        (r_h_cnt <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    assign o_vsync  = !((r_v_cnt >= CNT_W'(V_ACTIVE + V_FP)) &&
                        (r_v_cnt <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
    assign o_active = (r_v_cnt < CNT_W'(V_ACTIVE)) && (r_h_cnt < CNT_W'(H_ACTIVE));

endmodule

// File: rtl/vga_hw_sink.sv
// Hardware end of the VGA write handshake: stores pushed pixels in an on-chip framebuffer
// and scans it out as VGA RGB332 with 4x4 pixel replication.
module vga_hw_sink
    import vga_hw_sink_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int FB_W     = DEF_FB_W,
    parameter int FB_H     = DEF_FB_H,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] phy_addr,
    input  logic [31:0] phy_data,
    input  logic        hw_write,
    output logic        hw_done,
    output logic        addr_err,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [2:0]  vga_r,
    output logic [2:0]  vga_g,
    output logic [1:0]  vga_b
);

    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int FB_AW    = $clog2(FB_DEPTH);

    wr_state_t        r_state;
    wr_state_t        w_state_nxt;
    logic [31:0]      r_addr;
    logic [7:0]       r_data;
    logic             r_addr_err;
    logic [31:0]      w_wr_off;
    logic             w_wr_ok;
    logic             w_latch;
    logic             w_wr_en;

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_hsync;
    logic             w_vsync;
    logic             w_active;
    logic [FB_AW-1:0] w_rd_idx;

    logic [7:0]       r_mem [FB_DEPTH];
    logic [7:0]       r_rd_data;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_active;
    logic             w_unused;

    // Below-window addresses wrap to huge offsets, so one unsigned compare covers both ends.
    assign w_wr_off = r_addr - BASE_ADDR;
    assign w_wr_ok  = in_window(w_wr_off, FB_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (hw_write) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_wr_en     = w_wr_ok;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (!hw_write) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_latch) begin
                r_addr <= phy_addr;
                r_data <= phy_data[7:0];
            end
            if (r_state == ST_WRITE && !w_wr_ok) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign hw_done  = (r_state == ST_DONE);
    assign addr_err = r_addr_err;

    vga_hw_sink_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_tim (
        .i_clk    (clk),
        .i_rst    (rst),
        .o_h_cnt  (w_h_cnt),
        .o_v_cnt  (w_v_cnt),
        .o_hsync  (w_hsync),
        .o_vsync  (w_vsync),
        .o_active (w_active)
    );

    // Blanking lines would index past the buffer, so the read address parks at 0 there.
    assign w_rd_idx = w_active ?
        FB_AW'(w_v_cnt[CNT_W-1:2]) * FB_AW'(FB_W) + FB_AW'(w_h_cnt[CNT_W-1:2]) : '0;

    // Read-before-write on a same-index collision: the scan sees the old pixel this frame.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_off[FB_AW-1:0]] <= r_data;
        end
        r_rd_data <= r_mem[w_rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_active <= 1'b0;
        end else begin
            r_hsync  <= w_hsync;
            r_vsync  <= w_vsync;
            r_active <= w_active;
        end
    end

    assign vga_hsync              = r_hsync;
    assign vga_vsync              = r_vsync;
    assign {vga_r, vga_g, vga_b}  = r_active ? r_rd_data : 8'h00;

    assign w_unused = ^{phy_data[31:8], w_h_cnt[1:0], w_v_cnt[1:0]};

endmodule
